// File: rtl/rx_flow_monitor.sv
// rx_flow_monitor: passive AXI-Stream sink that classifies received frames by
// flow (destination MAC byte 5) and keeps per-flow frame/byte counters, plus
// optional BAD/RUNT/UNMATCHED error counters, readable over AXI-Lite.
// Optional feature macro: RX_FLOW_MONITOR_ERR_EN enables the three error
// counters; without it those registers read 0 (errored frames are still
// excluded from the per-flow counters).
module rx_flow_monitor #(
    parameter int N_FLOWS          = 2,
    parameter int MIN_FRAME_LENGTH = 60,
    parameter int AXIL_ADDR_WIDTH  = 32,
    parameter int AXIL_DATA_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [63:0]                  s_axis_tdata,
    input  logic [7:0]                   s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tuser,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]                   s_axil_awprot,
    input  logic                         s_axil_awvalid,
    output logic                         s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                         s_axil_wvalid,
    output logic                         s_axil_wready,
    output logic [1:0]                   s_axil_bresp,
    output logic                         s_axil_bvalid,
    input  logic                         s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]                   s_axil_arprot,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready
);

    localparam logic [31:0] MIN_LEN_U  = 32'(MIN_FRAME_LENGTH);
    localparam logic [31:0] N_FLOWS_U  = 32'(N_FLOWS);
    localparam logic [7:0]  N_FLOWS_B  = 8'(N_FLOWS);

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_MID   = 1'b1
    } state_e;

    // Number of valid bytes in a beat (tkeep is contiguous, but counting bits
    // is just as cheap and tolerates any pattern).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // 16-bit add that sticks at 0xFFFF instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  flow_q, flow_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  frame_flow;
    logic [15:0] frame_len;

    logic beat_acc;
    logic commit;
    logic is_bad, is_runt, is_unm, is_good;

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic        wr_fire, rd_fire, clr;
    logic [5:0]  wr_idx, rd_idx;
    logic [31:0] rd_word;

    logic [31:0] frames_q [N_FLOWS];
    logic [31:0] bytes_q  [N_FLOWS];

    // The monitor never stalls the MAC; it only refuses beats while in reset.
    assign s_axis_tready = rst_n;
    assign beat_acc      = s_axis_tvalid && s_axis_tready;
    assign commit        = beat_acc && s_axis_tlast;

    // Frame tracker: next state plus the flow/length as they stand after this beat.
    always_comb begin
        state_d    = state_q;
        flow_d     = flow_q;
        len_d      = len_q;
        frame_flow = (state_q == ST_FIRST) ? s_axis_tdata[47:40] : flow_q;
        frame_len  = sat_add16((state_q == ST_FIRST) ? 16'h0000 : len_q,
                               {12'h000, popcount8(s_axis_tkeep)});
        if (beat_acc) begin
            state_d = s_axis_tlast ? ST_FIRST : ST_MID;
            flow_d  = frame_flow;
            len_d   = frame_len;
        end
    end

    // Frame tracker state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FIRST;
            flow_q  <= 8'h00;
            len_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            flow_q  <= flow_d;
            len_q   <= len_d;
        end
    end

    // Classification in priority order: bad, then runt, then unmatched flow.
    assign is_bad  = s_axis_tuser;
    assign is_runt = !is_bad && ({16'h0000, frame_len} < MIN_LEN_U);
    assign is_unm  = !is_bad && !is_runt && ({24'h000000, frame_flow} >= N_FLOWS_U);
    assign is_good = !is_bad && !is_runt && !is_unm;

    // A counter clear takes precedence over a frame committed in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < N_FLOWS; f++) begin
                frames_q[f] <= 32'h0;
                bytes_q[f]  <= 32'h0;
            end
        end else if (clr) begin
            for (int f = 0; f < N_FLOWS; f++) begin
                frames_q[f] <= 32'h0;
                bytes_q[f]  <= 32'h0;
            end
        end else if (commit && is_good) begin
            for (int f = 0; f < N_FLOWS; f++) begin
                if (frame_flow == 8'(f)) begin
                    frames_q[f] <= frames_q[f] + 32'd1;
                    bytes_q[f]  <= bytes_q[f] + {16'h0000, frame_len};
                end
            end
        end
    end

`ifdef RX_FLOW_MONITOR_ERR_EN
    logic [31:0] bad_q, runt_q, unm_q;

    // Error counters, cleared alongside the per-flow counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q  <= 32'h0;
            runt_q <= 32'h0;
            unm_q  <= 32'h0;
        end else if (clr) begin
            bad_q  <= 32'h0;
            runt_q <= 32'h0;
            unm_q  <= 32'h0;
        end else if (commit) begin
            if (is_bad)  bad_q  <= bad_q + 32'd1;
            if (is_runt) runt_q <= runt_q + 32'd1;
            if (is_unm)  unm_q  <= unm_q + 32'd1;
        end
    end
`endif

    // AXI-Lite handshakes: one outstanding write and one outstanding read.
    assign wr_idx  = s_axil_awaddr[7:2];
    assign rd_idx  = s_axil_araddr[7:2];
    assign wr_fire = awready_q && s_axil_awvalid && s_axil_wvalid;
    assign rd_fire = arready_q && s_axil_arvalid;
    assign clr     = wr_fire && (wr_idx == 6'd0) && s_axil_wdata[0];

    // Register read mux; unmapped offsets read as zero.
    always_comb begin
        rd_word = 32'h0;
        if (rd_idx == 6'd0) rd_word = {N_FLOWS_B, 24'h000000};
`ifdef RX_FLOW_MONITOR_ERR_EN
        if (rd_idx == 6'd1) rd_word = bad_q;
        if (rd_idx == 6'd2) rd_word = runt_q;
        if (rd_idx == 6'd3) rd_word = unm_q;
`endif
        for (int f = 0; f < N_FLOWS; f++) begin
            if (rd_idx == 6'(4 + 2 * f)) rd_word = frames_q[f];
            if (rd_idx == 6'(5 + 2 * f)) rd_word = bytes_q[f];
        end
    end

    // AXI-Lite next-state: ready pulses for one cycle, valids held until taken.
    always_comb begin
        awready_d = s_axil_awvalid && s_axil_wvalid && !bvalid_q && !awready_q;
        arready_d = s_axil_arvalid && !rvalid_q && !arready_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (wr_fire) begin
            bvalid_d = 1'b1;
        end else if (s_axil_bready) begin
            bvalid_d = 1'b0;
        end
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end else if (s_axil_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // AXI-Lite channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = awready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = 2'b00;

    // Inputs that carry no information for this block (prot, strobes, payload).
    logic unused_ok;
    assign unused_ok = ^{s_axis_tdata, s_axil_awaddr, s_axil_awprot, s_axil_wdata,
                         s_axil_wstrb, s_axil_araddr, s_axil_arprot};

endmodule
